// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MaxNet winner-take-all sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maxnet_pkg;

  // Default iteration counter width
  localparam int DEFAULT_CNT_W = 8;

  // Settle counter width; covers PU latencies 1..15
  localparam int SETTLE_W = 4;

  // load_sel encoding toward the datapath
  localparam logic LOAD_SEL_MEM = 1'b1;
  localparam logic LOAD_SEL_PU  = 1'b0;

  // Controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/maxnet_controller_settle_counter.sv
// Loadable down-counter that times the PU pipeline settle window.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none; decrements only while dec is asserted and the count is non-zero.
module settle_counter
  import maxnet_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  // Load has priority over decrement; never underflows
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  // Asserted when the decrement in this cycle brings the count to zero,
  // so a window loaded with N lasts exactly N decrementing cycles
  assign zero = (count_q <= W'(1));

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer for the 4-neuron MaxNet datapath: load X, iterate PU feedback until one winner.
// Latency: start to done = PU_LATENCY+3 cycles, plus PU_LATENCY+2 per feedback iteration.
// Backpressure: start is sampled in IDLE only; optional MAXNET_TIMEOUT_EN bounds iterations at MAX_ITER.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int PU_LATENCY = 1,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int MAX_ITER   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_finished,
  output logic             load_a,
  output logic             load_sel,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             timeout
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(PU_LATENCY);

  state_t state, state_nxt;
  logic   settle_load;
  logic   settle_dec;
  logic   settle_zero;
  logic   start_acc;
  logic   finish_run;
  logic   limit_hit;

`ifdef MAXNET_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);
  assign limit_hit = (iter_cnt == ITER_LIMIT);
`else
  assign limit_hit = 1'b0;
`endif

  settle_counter #(
    .W (SETTLE_W)
  ) u_settle (
    .clk   (clk),
    .rst   (rst),
    .load  (settle_load),
    .value (SETTLE_LOAD),
    .dec   (settle_dec),
    .zero  (settle_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nxt   = state;
    load_a      = 1'b0;
    load_sel    = LOAD_SEL_PU;
    busy        = 1'b1;
    done        = 1'b0;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    start_acc   = 1'b0;
    finish_run  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_a      = 1'b1;
        load_sel    = LOAD_SEL_MEM;
        settle_load = 1'b1;
        state_nxt   = SETTLE;
      end
      SETTLE: begin
        settle_dec = 1'b1;
        if (settle_zero) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        // A converged result wins over the iteration limit
        if (is_finished || limit_hit) begin
          finish_run = 1'b1;
          state_nxt  = DONE;
        end else begin
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        load_a      = 1'b1;
        settle_load = 1'b1;
        state_nxt   = SETTLE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Iteration count (saturating) and result-valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt  <= '0;
      res_valid <= 1'b0;
    end else if (start_acc) begin
      iter_cnt  <= '0;
      res_valid <= 1'b0;
    end else begin
      if ((state == UPDATE) && (iter_cnt != '1)) begin
        iter_cnt <= iter_cnt + CNT_W'(1);
      end
      if (finish_run) begin
        res_valid <= 1'b1;
      end
    end
  end

`ifdef MAXNET_TIMEOUT_EN
  // Timeout flag: set when the run ends on the limit without convergence
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if (start_acc) begin
      timeout <= 1'b0;
    end else if (finish_run && !is_finished) begin
      timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller with a small datapath model.
// Latency: expected start-to-done latency derived from PU_LATENCY and iteration count.
// Backpressure: start pulses and holds exercised; waits are cycle-bounded.
module tb_maxnet_controller;

  localparam int PL = 2;
  localparam int CW = 8;
  localparam int MI = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          is_finished;
  logic          load_a;
  logic          load_sel;
  logic          busy;
  logic          done;
  logic          res_valid;
  logic [CW-1:0] iter_cnt;
  logic          timeout;

  always #5 clk = ~clk;

  maxnet_controller #(
    .PU_LATENCY (PL),
    .CNT_W      (CW),
    .MAX_ITER   (MI)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_finished (is_finished),
    .load_a      (load_a),
    .load_sel    (load_sel),
    .busy        (busy),
    .done        (done),
    .res_valid   (res_valid),
    .iter_cnt    (iter_cnt),
    .timeout     (timeout)
  );

  // Datapath model: converges after `target` PU feedback loads since the last X load
  int target;
  int pu_loads;
  always @(posedge clk) begin
    if (rst) pu_loads <= 0;
    else if (load_a && load_sel) pu_loads <= 0;
    else if (load_a) pu_loads <= pu_loads + 1;
  end
  assign is_finished = (pu_loads >= target);

  typedef struct {
    int target;
    int iter;
    int lat;
    bit to;
  } vec_t;

  typedef struct {
    int iter;
    int lat;
    bit to;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int lat_of(input int iters);
    return PL + 3 + iters * (PL + 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " load_a"}, int'(load_a), 0);
    check({tag, " load_sel"}, int'(load_sel), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " res_valid"}, int'(res_valid), 0);
    check({tag, " iter_cnt"}, int'(iter_cnt), 0);
    check({tag, " timeout"}, int'(timeout), 0);
  endtask

  // One run: push expectation, drive start, watch the run, compare at done
  task automatic run_one(input vec_t v, input bit hold_start);
    exp_t e;
    exp_t got;
    int   n = 0;
    int   nmem = 0, nupd = 0, busy_low = 0, sel_bad = 0, rv_early = 0;
    bit   seen = 1'b0;
    e.iter = v.iter; e.lat = v.lat; e.to = v.to;
    target = v.target;
    start  = 1'b1;
    sb.push_back(e);
    for (int k = 0; k < 2000 && !seen; k++) begin
      tick();
      n++;
      if (!hold_start) start = 1'b0;
      if (load_a && load_sel) nmem++;
      if (load_a && !load_sel) nupd++;
      if (!load_a && load_sel) sel_bad++;
      if (!busy) busy_low++;
      if (res_valid && !done) rv_early++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      check("done wait expired", 0, 1);
      if (sb.size() > 0) void'(sb.pop_back());
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard empty at done", 0, 1);
      return;
    end
    got = sb.pop_front();
    check("latency", n, got.lat);
    check("iter_cnt", int'(iter_cnt), got.iter);
    check("timeout", int'(timeout), int'(got.to));
    check("res_valid at done", int'(res_valid), 1);
    check("busy at done", int'(busy), 1);
    check("X loads", nmem, 1);
    check("PU loads", nupd, got.iter);
    check("busy dropped in run", busy_low, 0);
    check("load_sel without load_a", sel_bad, 0);
    check("res_valid before done", rv_early, 0);
    tick();
    check("done one cycle", int'(done), 0);
    check("busy after done", int'(busy), 0);
    check("res_valid held", int'(res_valid), 1);
    check("timeout held", int'(timeout), int'(got.to));
  endtask

  vec_t tbl[$];

  initial begin
    int t0;
    int cnt;
    bit found;
    vec_t v;

    // Vector table: {target iterations, expected iter_cnt, expected latency, expected timeout}
    tbl.push_back('{0, 0, lat_of(0), 1'b0});
    tbl.push_back('{3, 3, lat_of(3), 1'b0});
    tbl.push_back('{1, 1, lat_of(1), 1'b0});
    tbl.push_back('{4, 4, lat_of(4), 1'b0});
`ifdef MAXNET_TIMEOUT_EN
    tbl.push_back('{100000, MI, lat_of(MI), 1'b1});
    tbl.push_back('{MI, MI, lat_of(MI), 1'b0});
    tbl.push_back('{2, 2, lat_of(2), 1'b0});
`else
    tbl.push_back('{7, 7, lat_of(7), 1'b0});
`endif

    rst = 1'b1; start = 1'b0; target = 0;
    tick(); tick(); tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_one(tbl[i], 1'b0);
      tick();
    end

    // Reset during the second SETTLE: outputs clear, no done, next run is fresh
    target = 3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (load_a && !load_sel) found = 1'b1;
      else tick();
    end
    check("reached first UPDATE", int'(found), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midrun reset");
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done || busy) cnt++;
    end
    check("activity after reset", cnt, 0);
    v = '{2, 2, lat_of(2), 1'b0};
    run_one(v, 1'b0);
    tick();

    // start held high through the whole run has no effect while busy
    v = '{2, 2, lat_of(2), 1'b0};
    run_one(v, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    check("res_valid held idle", int'(res_valid), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("res_valid cleared by start", int'(res_valid), 0);
    check("load after start", int'(load_a & load_sel), 1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (done) found = 1'b1;
    end
    check("rerun done", int'(found), 1);
    check("rerun iter_cnt", int'(iter_cnt), 2);
    tick();

    // Continuous start: restart on the cycle after DONE
    target = 1;
    start  = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (done) found = 1'b1;
    end
    check("first continuous done", int'(found), 1);
    t0 = 0;
    tick();
    t0++;
    check("idle after done busy", int'(busy), 0);
    check("idle after done res_valid", int'(res_valid), 1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      t0++;
      if (done) found = 1'b1;
    end
    start = 1'b0;
    check("continuous restart gap", t0, lat_of(1) + 1);
    check("continuous iter_cnt", int'(iter_cnt), 1);
    tick(); tick(); tick();
    check("no third run", int'(busy), 0);

`ifndef MAXNET_TIMEOUT_EN
    // No convergence, no limit: stays busy, counter saturates, never times out
    target = 100000;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    cnt = 0;
    for (int k = 0; k < 1200; k++) begin
      tick();
      if (done || !busy) cnt++;
    end
    check("stuck run ended", cnt, 0);
    check("iter_cnt saturated", int'(iter_cnt), (1 << CW) - 1);
    check("stuck timeout", int'(timeout), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("post-stuck reset");
`endif

    check("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
Name: maxnet_controller

Overview:
- Sequencer for the 4-neuron MaxNet winner-take-all datapath.
- On `start` it loads the input vector X into the neuron registers, then repeatedly latches the PU outputs back into the neuron registers until the datapath reports `is_finished`.
- Drives the datapath's `load_a`/`load_sel`, waits out PU pipeline latency, counts iterations, signals completion to the top level.

Parameters:
- PU_LATENCY, 1, clock cycles from a neuron-register update until PU outputs and `is_finished` are valid (range 1..15).
- CNT_W, 8, width of the iteration counter.
- MAX_ITER, 255, iteration limit; only used when MAXNET_TIMEOUT_EN is defined; must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new MaxNet run; level-sampled in IDLE only
- is_finished  input  1  datapath flag: exactly one neuron register non-zero
- load_a  output  1  neuron register load enable, to datapath
- load_sel  output  1  1 = load memory X into neuron registers, 0 = load PU outputs
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse when the run completes
- res_valid  output  1  datapath `res` is valid; held until next start accepted
- iter_cnt  output  CNT_W  number of PU-feedback iterations in the current/last run
- timeout  output  1  run ended at MAX_ITER without convergence (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous, active-high.
- Reset values: all outputs are 0. State is IDLE and the settle counter is 0. `iter_cnt` is 0.
- Reset mid-run: reset on any edge, in any state, returns to IDLE with all outputs 0. No `done` pulse is produced.
- IDLE: `busy`=0, `load_a`=0.
  - `start`=1 goes to LOAD, clears `iter_cnt`, `res_valid` and `timeout`.
  - `res_valid` otherwise holds its value.
- LOAD (1 cycle): `load_a`=1, `load_sel`=1, `busy`=1. Next state SETTLE with the settle counter set to PU_LATENCY.
- SETTLE: `load_a`=0, `load_sel`=0. The counter decrements each cycle; on reaching 0 go to CHECK.
  - SETTLE lasts exactly PU_LATENCY cycles.
- CHECK (1 cycle): `is_finished` is sampled here only.
  - 1: go to DONE.
  - 0: go to UPDATE.
- UPDATE (1 cycle): `load_a`=1, `load_sel`=0, `iter_cnt` += 1. Next state SETTLE, counter reloaded to PU_LATENCY.
- DONE (1 cycle): `done`=1, `res_valid` set to 1, `busy`=0 on the following cycle. Next state IDLE.
- `start` is ignored in every state except IDLE. `start` held high continuously restarts a run on the cycle after DONE.
- Iteration count saturates at 2^CNT_W-1 and never wraps.
- Input already converged: LOAD, SETTLE, CHECK, DONE, with `iter_cnt`=0. Latency from start to `done` is PU_LATENCY+3 cycles.
- Each extra iteration adds PU_LATENCY+2 cycles.
- `load_sel` is don't-care when `load_a`=0, but is driven 0.
- Outputs are registered where noted above. `load_a`, `load_sel` and `done` are state-decoded (Moore).

Optional Feature:
- Macro: MAXNET_TIMEOUT_EN.
- Defined: in CHECK, if `is_finished`=0 and `iter_cnt`==MAX_ITER, go to DONE with `timeout`=1 and `res_valid`=1.
  - `timeout` holds until the next start is accepted or reset.
  - `is_finished`=1 takes priority over timeout in the same cycle.
- Undefined: no limit; the run continues until `is_finished`. The `timeout` port is tied 0. MAX_ITER is unused.

Decomposition:
- Package `maxnet_pkg`:
  - state enum {IDLE, LOAD, SETTLE, CHECK, UPDATE, DONE}
  - default CNT_W
  - settle-counter width constant (4 bits)
  - `LOAD_SEL_MEM`=1 / `LOAD_SEL_PU`=0 constants
- One sub-module: `settle_counter`, a loadable down-counter with sync reset, `load`/`value` inputs and a `zero` output.

Test Plan:
- Converged input: PU_LATENCY=1, `is_finished`=1 from first CHECK, start pulse at cycle 0. Expect `load_a`/`load_sel`=1 at cycle 1 and `done` at cycle 4, with `iter_cnt`=0, `res_valid`=1.
- Three iterations: `is_finished` asserted at the 4th CHECK. Expect 3 UPDATE cycles with `load_a`=1, `load_sel`=0, then `done` with `iter_cnt`=3. With PU_LATENCY=2, `done` comes 17 cycles after start.
- Mid-run reset: rst=1 during the second SETTLE. Next cycle: all outputs 0 and IDLE; no `done` pulse; a following start behaves like a fresh run.
- Start while busy: pulse `start` during SETTLE and UPDATE. No effect on state or `iter_cnt`. `res_valid` holds 1 after DONE until the next accepted start clears it.
- Timeout (MAXNET_TIMEOUT_EN defined, MAX_ITER=5, `is_finished` stuck 0): expect `done` with `timeout`=1, `iter_cnt`=5. Without the macro, `busy` stays high for more than 1000 cycles and `timeout`=0.
- Priority (MAXNET_TIMEOUT_EN defined, MAX_ITER=2, `is_finished`=1 at the CHECK where `iter_cnt`=2): expect `done`=1 and `timeout`=0.
